// File: rtl/instr_register_pipe_pkg.sv
// Shared types for the pipelined instruction register file.
// Defines the opcode set, the stored instruction word layout and its cleared value.
// No logic; imported by the top module and the execute unit.
package instr_register_pipe_pkg;

    // Operand width baked into the stored word; the top-level OP_WIDTH must match it.
    localparam int IW_OP_WIDTH = 32;

    // Opcodes 8..15 are legal on the bus but have no name; they execute as a no-op.
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    // One array entry: the instruction as received plus its computed outcome.
    typedef struct packed {
        opcode_t                           opc;
        logic signed [IW_OP_WIDTH-1:0]     op_a;
        logic signed [IW_OP_WIDTH-1:0]     op_b;
        logic signed [2*IW_OP_WIDTH-1:0]   result;
        logic                              div0;
        logic                              vld;
    } iw_t;

    // Value of an entry that has never been written.
    localparam iw_t IW_ZERO = '{
        opc:    ZERO,
        op_a:   '0,
        op_b:   '0,
        result: '0,
        div0:   1'b0,
        vld:    1'b0
    };

endpackage

// File: rtl/irp_alu.sv
// Execute unit: signed result of opcode applied to two sign-extended operands.
// Latency: purely combinational, registered by the caller.
// Backpressure: none, evaluates every cycle whether or not the input is valid.
module irp_alu
    import instr_register_pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  opcode_t        opcode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] result,
    output logic           div0
);

    // Working at 2*W means every product/sum/quotient of W-bit signed values fits,
    // including most-negative / -1, so no overflow handling is needed.
    logic signed [2*W-1:0] a_ext;
    logic signed [2*W-1:0] b_ext;

    // Sign-extend operands and select the operation; divide-by-zero yields 0 with a flag.
    always_comb begin
        a_ext  = {{W{a[W-1]}}, a};
        b_ext  = {{W{b[W-1]}}, b};
        result = '0;
        div0   = 1'b0;
        case (opcode)
            ZERO:    result = '0;
            PASSA:   result = a_ext;
            PASSB:   result = b_ext;
            ADD:     result = a_ext + b_ext;
            SUB:     result = a_ext - b_ext;
            MULT:    result = a_ext * b_ext;
            DIV: begin
                if (b_ext == '0) begin
                    div0 = 1'b1;
                end else begin
                    result = a_ext / b_ext;
                end
            end
            MOD: begin
                if (b_ext == '0) begin
                    div0 = 1'b1;
                end else begin
                    result = a_ext % b_ext;
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_pipe.sv
// Pipelined instruction register file: capture, execute, then store the full word in an array.
// Latency: transfer at edge N is written at edge N+2; reads return one edge after request, with forwarding.
// Backpressure: load_ready drops only in sequential mode with WRAP_EN=0 once every entry is spoken for.
module instr_register_pipe
    import instr_register_pipe_pkg::*;
#(
    parameter int OP_WIDTH = IW_OP_WIDTH,
    parameter int DEPTH    = 32,
    parameter bit WRAP_EN  = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic                seq_mode,
    input  logic [3:0]          opcode,
    input  logic [OP_WIDTH-1:0] operand_a,
    input  logic [OP_WIDTH-1:0] operand_b,
    input  logic [AW-1:0]       write_pointer,
    input  logic                read_en,
    input  logic [AW-1:0]       read_pointer,
    output logic                rd_valid,
    output iw_t                 instruction_word,
    output logic [AW:0]         count,
    output logic                full
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    // Front end
    logic          transfer;
    logic [AW-1:0] tgt_addr;
    logic [AW-1:0] wptr;

    // Entries that have been targeted by an accepted transfer, whether or not the
    // write has landed yet. Its population is count plus in-flight fresh writes.
    logic [DEPTH-1:0] claimed;
    logic [AW:0]      claim_cnt;
    logic             full_next;

    // Stage 1: captured instruction
    logic                s1_vld;
    opcode_t             s1_opc;
    logic [OP_WIDTH-1:0] s1_a;
    logic [OP_WIDTH-1:0] s1_b;
    logic [AW-1:0]       s1_addr;

    // Execute outputs
    logic [2*OP_WIDTH-1:0] alu_result;
    logic                  alu_div0;

    // Stage 2: completed word waiting for its array write
    logic          s2_vld;
    iw_t           s2_iw;
    logic [AW-1:0] s2_addr;

    // Storage
    iw_t mem [DEPTH];

    assign full_next  = (claim_cnt == DEPTH_CNT);
    assign load_ready = !(seq_mode && !WRAP_EN && full_next);
    assign transfer   = load_valid && load_ready;
    assign tgt_addr   = seq_mode ? wptr : write_pointer;
    assign full       = (count == DEPTH_CNT);

    // Sequential pointer advances only on transfers taken in sequential mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
        end else if (transfer && seq_mode) begin
            wptr <= wptr + AW'(1);
        end
    end

    // Reserve the target entry at acceptance so backpressure accounts for in-flight writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            claimed   <= '0;
            claim_cnt <= '0;
        end else if (transfer && !claimed[tgt_addr]) begin
            claimed[tgt_addr] <= 1'b1;
            claim_cnt         <= claim_cnt + (AW+1)'(1);
        end
    end

    // Stage 1 captures the accepted instruction and its resolved target address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_opc  <= ZERO;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_addr <= '0;
        end else begin
            s1_vld <= transfer;
            if (transfer) begin
                s1_opc  <= opcode_t'(opcode);
                s1_a    <= operand_a;
                s1_b    <= operand_b;
                s1_addr <= tgt_addr;
            end
        end
    end

    irp_alu #(
        .W (OP_WIDTH)
    ) u_alu (
        .opcode (s1_opc),
        .a      (s1_a),
        .b      (s1_b),
        .result (alu_result),
        .div0   (alu_div0)
    );

    // Stage 2 registers the finished word, marked valid for storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_vld  <= 1'b0;
            s2_iw   <= IW_ZERO;
            s2_addr <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_iw <= '{
                    opc:    s1_opc,
                    op_a:   s1_a,
                    op_b:   s1_b,
                    result: alu_result,
                    div0:   alu_div0,
                    vld:    1'b1
                };
                s2_addr <= s1_addr;
            end
        end
    end

    // Array write; reset clears every entry so nothing in flight survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= IW_ZERO;
            end
        end else if (s2_vld) begin
            mem[s2_addr] <= s2_iw;
        end
    end

    // Count first-time fills only; overwrites of a valid entry leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (s2_vld && !mem[s2_addr].vld) begin
            count <= count + (AW+1)'(1);
        end
    end

    // Registered read; a write landing on the same entry this edge is returned directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid         <= 1'b0;
            instruction_word <= IW_ZERO;
        end else begin
            rd_valid <= read_en;
            if (read_en) begin
                if (s2_vld && (s2_addr == read_pointer)) begin
                    instruction_word <= s2_iw;
                end else begin
                    instruction_word <= mem[read_pointer];
                end
            end
        end
    end

endmodule
